pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and selects the next fetch address each cycle: sequential, ID-stage jump (J/JAL) and jump-register (JR), or EX-stage taken branch.
- Generates the IF/ID flush pulses that go with a redirect, and honours the hazard-unit stall.
- Sits between the hazard unit, the ID/EX stages and the instruction memory address port.
- Computes the J-type target internally as {id_pc_plus4[31:28], jump_field, 2'b00}.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- id_jump  in  1  J/JAL decoded in ID.
- id_jr  in  1  JR decoded in ID.
- id_pc_plus4  in  32  PC+4 of the instruction in ID.
- jump_field  in  26  instr[25:0] of the ID instruction.
- jr_target  in  32  forwarded rs value for JR.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_branch_target  in  32  branch target from EX.
- halt_req  in  1  BREAK/SYSCALL-halt decoded in ID.
- pc  out  32  current fetch address (registered).
- pc_plus4  out  32  pc + 4, combinational.
- fetch_valid  out  1  instruction memory read is meaningful.
- flush_if  out  1  clear IF/ID register at the next edge.
- flush_id  out  1  clear ID/EX register at the next edge.
- halted  out  1  core halted.
- misalign_err  out  1  sticky: redirect target[1:0] != 0.
- redirect_cnt  out  CNT_W  number of redirects taken, saturating.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on the rising clk edge.
- Reset values: pc=RESET_PC, state=BOOT, fetch_valid=0, flush_if=0, flush_id=0, halted=0, misalign_err=0, redirect_cnt=0.
- Reset asserted mid-redirect or while in HALT wins unconditionally.
- States:
  - BOOT: one cycle, fetch_valid=0, pc held, then RUN unconditionally.
  - RUN: fetch_valid=1. Events are evaluated combinationally each cycle, highest priority first:
    1. ex_branch_taken: next pc=ex_branch_target; flush_if=1, flush_id=1. Overrides stall and any ID jump/halt in the same cycle, because the ID instruction is on the wrong path.
    2. id_jr with stall=0: next pc=jr_target; flush_if=1.
    3. id_jump with stall=0: next pc={id_pc_plus4[31:28], jump_field, 2'b00}; flush_if=1.
    4. halt_req with stall=0: pc held; next state HALT.
    5. stall=1: pc held; no flush.
    6. Otherwise: next pc=pc+4.
  - HALT: fetch_valid=0, halted=1, pc frozen, all inputs ignored, flushes 0. Exit only by reset.
- Jump and JR requests seen while stall=1 are not acted on; they are re-evaluated when stall drops. id_jr and id_jump both high: JR wins.
- Flushes are combinational in the redirect cycle only, so they are exactly one-cycle pulses aligned with the PC update edge.
- Misaligned redirect (a priority-1..3 target with [1:0] != 0): pc is not updated, misalign_err is set (sticky until reset), next state HALT, and no flush is driven.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000) silently.
  - The J-target upper nibble comes from id_pc_plus4, never from pc.
- redirect_cnt increments by 1 on each accepted aligned redirect and saturates at all-ones.
- Latency: redirect decision to new pc = 1 cycle. Redirect penalty: branch 2 bubbles, jump 1 bubble.

Decomposition:
- Shared package (cpu_pkg):
  - state enum {BOOT, RUN, HALT}.
  - Next-PC select enum {SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JR, SEL_J}.
  - Constants INSTR_BYTES=4 and RESET_PC default.
- One combinational sub-module, next_pc_select: priority encoder producing the select code, flush_if, flush_id and target. Its decode is unit-testable on its own.
- PC register, FSM and counter stay in pc_sequencer.

Test Plan:
- Reset then release -> cycle 0: pc=0, fetch_valid=0; cycle 1: fetch_valid=1, pc=0; cycle 2: pc=4; cycle 3: pc=8.
- id_jump=1, jump_field=26'h0000100, id_pc_plus4=32'h1000_0008, stall=0 -> next pc=32'h1000_0400, flush_if=1 for 1 cycle, flush_id=0, redirect_cnt=1.
- ex_branch_taken=1, target=32'h0000_0040, same cycle as id_jr=1 and stall=1 -> next pc=0x40, flush_if=flush_id=1; the JR is dropped.
- id_jump=1 with stall=1 for 3 cycles, then stall=0 -> pc held 3 cycles with no flush, then redirect on the 4th edge.
- id_jr=1, jr_target=32'h0000_0102 -> pc unchanged, misalign_err=1, halted=1, fetch_valid=0; a later reset clears all three.
- Force pc to 0xFFFF_FFFC via branch, then run 1 cycle -> pc=0x0000_0000. Issue 2^CNT_W+3 jumps -> redirect_cnt stays at all-ones.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch-side program counter logic.
// Holds the FSM states, the next-PC select codes and the J-type target helper.
package cpu_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BR,
        SEL_JR,
        SEL_J
    } pc_sel_e;

    // The upper nibble comes from the ID instruction's PC+4, not from the fetch PC.
    function automatic logic [31:0] j_target(input logic [31:0] pc_plus4,
                                             input logic [25:0] field);
        return {pc_plus4[31:28], field, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of hazard/ID/EX requests and fetch-side outputs of the PC sequencer.
// master = the sequencer itself, slave = the surrounding pipeline.
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic              stall;
    logic              id_jump;
    logic              id_jr;
    logic [31:0]       id_pc_plus4;
    logic [25:0]       jump_field;
    logic [31:0]       jr_target;
    logic              ex_branch_taken;
    logic [31:0]       ex_branch_target;
    logic              halt_req;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              fetch_valid;
    logic              flush_if;
    logic              flush_id;
    logic              halted;
    logic              misalign_err;
    logic [CNT_W-1:0]  redirect_cnt;

    modport master (
        input  stall, id_jump, id_jr, id_pc_plus4, jump_field, jr_target,
               ex_branch_taken, ex_branch_target, halt_req,
        output pc, pc_plus4, fetch_valid, flush_if, flush_id, halted,
               misalign_err, redirect_cnt
    );

    modport slave (
        output stall, id_jump, id_jr, id_pc_plus4, jump_field, jr_target,
               ex_branch_taken, ex_branch_target, halt_req,
        input  pc, pc_plus4, fetch_valid, flush_if, flush_id, halted,
               misalign_err, redirect_cnt
    );

endinterface

// File: rtl/pc_sequencer_next_pc_select.sv
// Priority encoder for the next fetch address: branch > JR > J > halt > stall > sequential.
// Purely combinational; the caller gates its outputs with the RUN state.
module next_pc_select
    import cpu_pkg::*;
(
    input  logic        stall,
    input  logic        id_jump,
    input  logic        id_jr,
    input  logic [31:0] id_pc_plus4,
    input  logic [25:0] jump_field,
    input  logic [31:0] jr_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        halt_req,
    output pc_sel_e     sel,
    output logic [31:0] target,
    output logic        flush_if,
    output logic        flush_id,
    output logic        misalign,
    output logic        go_halt
);

    pc_sel_e req;

    always_comb begin
        req      = SEL_SEQ;
        sel      = SEL_SEQ;
        target   = ex_branch_target;
        flush_if = 1'b0;
        flush_id = 1'b0;
        misalign = 1'b0;
        go_halt  = 1'b0;

        // A taken branch means the ID instruction is on the wrong path, so stall is moot.
        if (ex_branch_taken) begin
            req    = SEL_BR;
            target = ex_branch_target;
        end else if (!stall && id_jr) begin
            req    = SEL_JR;
            target = jr_target;
        end else if (!stall && id_jump) begin
            req    = SEL_J;
            target = j_target(id_pc_plus4, jump_field);
        end else if (!stall && halt_req) begin
            req     = SEL_HOLD;
            go_halt = 1'b1;
        end else if (stall) begin
            req = SEL_HOLD;
        end

        sel = req;
        if (req == SEL_BR || req == SEL_JR || req == SEL_J) begin
            // A misaligned target is refused outright: no PC move, no flush.
            if (target[1:0] != 2'b00) begin
                misalign = 1'b1;
                sel      = SEL_HOLD;
            end else begin
                flush_if = 1'b1;
                flush_id = (req == SEL_BR);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, BOOT/RUN/HALT FSM and saturating redirect counter.
// Next-PC choice is delegated to next_pc_select; flushes are live only in RUN.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             halted_q, halted_d;
    logic             misalign_err_q, misalign_err_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    pc_sel_e     sel;
    logic [31:0] target;
    logic        sel_flush_if;
    logic        sel_flush_id;
    logic        sel_misalign;
    logic        sel_go_halt;
    logic        running;

    next_pc_select u_next_pc_select (
        .stall            (bus.stall),
        .id_jump          (bus.id_jump),
        .id_jr            (bus.id_jr),
        .id_pc_plus4      (bus.id_pc_plus4),
        .jump_field       (bus.jump_field),
        .jr_target        (bus.jr_target),
        .ex_branch_taken  (bus.ex_branch_taken),
        .ex_branch_target (bus.ex_branch_target),
        .halt_req         (bus.halt_req),
        .sel              (sel),
        .target           (target),
        .flush_if         (sel_flush_if),
        .flush_id         (sel_flush_id),
        .misalign         (sel_misalign),
        .go_halt          (sel_go_halt)
    );

    assign running = (state_q == RUN) && !reset;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        misalign_err_d = misalign_err_q;
        redirect_cnt_d = redirect_cnt_q;

        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                case (sel)
                    SEL_SEQ: pc_d = pc_q + 32'(INSTR_BYTES);
                    SEL_BR, SEL_JR, SEL_J: begin
                        pc_d = target;
                        if (redirect_cnt_q != {CNT_W{1'b1}}) begin
                            redirect_cnt_d = redirect_cnt_q + 1'b1;
                        end
                    end
                    default: pc_d = pc_q;
                endcase
                if (sel_misalign) begin
                    misalign_err_d = 1'b1;
                    state_d        = HALT;
                end
                if (sel_go_halt) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase

        fetch_valid_d = (state_d == RUN);
        halted_d      = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            fetch_valid_q  <= 1'b0;
            halted_q       <= 1'b0;
            misalign_err_q <= 1'b0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_valid_q  <= fetch_valid_d;
            halted_q       <= halted_d;
            misalign_err_q <= misalign_err_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_q + 32'(INSTR_BYTES);
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.halted       = halted_q;
    assign bus.misalign_err = misalign_err_q;
    assign bus.redirect_cnt = redirect_cnt_q;
    assign bus.flush_if     = running && sel_flush_if;
    assign bus.flush_id     = running && sel_flush_id;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle model checked every negedge plus literal pins.
module tb_pc_sequencer;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 = booting, 1 = running, 2 = halted.
    int               m_mode  = 0;
    logic [31:0]      m_pc    = 32'h0;
    bit               m_err   = 1'b0;
    logic [CNT_W-1:0] m_cnt   = '0;
    bit               m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // What the spec says the current cycle's inputs request, when running.
    function automatic void redir(output bit act, output bit isbr, output logic [31:0] tgt);
        act = 1'b0; isbr = 1'b0; tgt = 32'h0;
        if (m_mode != 1) return;
        if (bus.ex_branch_taken) begin
            act = 1'b1; isbr = 1'b1; tgt = bus.ex_branch_target;
        end else if (!bus.stall && bus.id_jr) begin
            act = 1'b1; tgt = bus.jr_target;
        end else if (!bus.stall && bus.id_jump) begin
            act = 1'b1;
            tgt = (bus.id_pc_plus4 & 32'hF000_0000) | ({6'd0, bus.jump_field} * 32'd4);
        end
    endfunction

    // Advance the model and the clock by one cycle; inputs change 2 units after the edge.
    task automatic tick();
        bit a, b;
        logic [31:0] t;
        int n_mode = m_mode;
        logic [31:0] n_pc = m_pc;
        bit n_err = m_err;
        logic [CNT_W-1:0] n_cnt = m_cnt;
        redir(a, b, t);
        if (reset) begin
            n_mode = 0; n_pc = 32'h0; n_err = 1'b0; n_cnt = '0;
        end else if (m_mode == 0) begin
            n_mode = 1;
        end else if (m_mode == 1) begin
            if (a) begin
                if (t % 4 != 0) begin
                    n_err = 1'b1; n_mode = 2;
                end else begin
                    n_pc = t;
                    if (m_cnt != CNT_MAX) n_cnt = m_cnt + 1'b1;
                end
            end else if (!bus.stall && bus.halt_req) begin
                n_mode = 2;
            end else if (!bus.stall) begin
                n_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        m_mode = n_mode; m_pc = n_pc; m_err = n_err; m_cnt = n_cnt;
        if (reset) m_known = 1'b1;
        #2;
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            bit a, b, fi;
            logic [31:0] t;
            redir(a, b, t);
            fi = !reset && a && (t[1:0] == 2'b00);
            chk("pc", bus.pc, m_pc);
            chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
            chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_mode == 1));
            chk("halted", 32'(bus.halted), 32'(m_mode == 2));
            chk("misalign_err", 32'(bus.misalign_err), 32'(m_err));
            chk("redirect_cnt", 32'(bus.redirect_cnt), 32'(m_cnt));
            chk("flush_if", 32'(bus.flush_if), 32'(fi));
            chk("flush_id", 32'(bus.flush_id), 32'(fi && b));
        end
    end

    task automatic idle();
        bus.stall = 0; bus.id_jump = 0; bus.id_jr = 0; bus.id_pc_plus4 = 0;
        bus.jump_field = 0; bus.jr_target = 0; bus.ex_branch_taken = 0;
        bus.ex_branch_target = 0; bus.halt_req = 0;
    endtask

    initial begin
        idle();
        tick(); tick();
        reset = 1'b0;
        // Boot sequence.
        chk("boot_pc", bus.pc, 32'h0);
        chk("boot_fv", 32'(bus.fetch_valid), 32'd0);
        tick();
        chk("run_fv", 32'(bus.fetch_valid), 32'd1);
        chk("run_pc0", bus.pc, 32'h0);
        tick(); chk("run_pc4", bus.pc, 32'h4);
        tick(); chk("run_pc8", bus.pc, 32'h8);

        // J-type redirect.
        bus.id_jump = 1; bus.jump_field = 26'h0000100; bus.id_pc_plus4 = 32'h1000_0008;
        #1;
        chk("j_flush_if", 32'(bus.flush_if), 32'd1);
        chk("j_flush_id", 32'(bus.flush_id), 32'd0);
        tick(); idle(); #1;
        chk("j_pc", bus.pc, 32'h1000_0400);
        chk("j_cnt", 32'(bus.redirect_cnt), 32'd1);
        chk("j_flush_end", 32'(bus.flush_if), 32'd0);

        // Branch beats a stalled JR.
        bus.ex_branch_taken = 1; bus.ex_branch_target = 32'h40;
        bus.id_jr = 1; bus.jr_target = 32'h200; bus.stall = 1;
        #1;
        chk("br_flush_if", 32'(bus.flush_if), 32'd1);
        chk("br_flush_id", 32'(bus.flush_id), 32'd1);
        tick(); idle();
        chk("br_pc", bus.pc, 32'h40);
        chk("br_cnt", 32'(bus.redirect_cnt), 32'd2);

        // Jump held off by stall for three cycles.
        bus.id_jump = 1; bus.jump_field = 26'h20; bus.id_pc_plus4 = 32'h50; bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_noflush", 32'(bus.flush_if), 32'd0);
            tick();
            chk("stall_pc", bus.pc, 32'h40);
        end
        bus.stall = 0; #1;
        chk("unstall_flush", 32'(bus.flush_if), 32'd1);
        tick(); idle();
        chk("unstall_pc", bus.pc, 32'h80);

        // Wrap at the top of the address space.
        bus.ex_branch_taken = 1; bus.ex_branch_target = 32'hFFFF_FFFC;
        tick(); idle();
        chk("wrap_pre", bus.pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus.pc_plus4, 32'h0);
        tick();
        chk("wrap_pc", bus.pc, 32'h0);

        // Counter saturation.
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            bus.id_jump = 1; bus.jump_field = 26'(i); bus.id_pc_plus4 = 32'h0;
            tick();
        end
        idle();
        chk("sat_cnt", 32'(bus.redirect_cnt), 32'(CNT_MAX));
        chk("sat_pc", bus.pc, 32'h48);

        // Misaligned JR halts without moving the PC; HALT ignores later requests.
        bus.id_jr = 1; bus.jr_target = 32'h102; #1;
        chk("mis_noflush", 32'(bus.flush_if), 32'd0);
        tick(); idle();
        chk("mis_pc", bus.pc, 32'h48);
        chk("mis_err", 32'(bus.misalign_err), 32'd1);
        chk("mis_halted", 32'(bus.halted), 32'd1);
        chk("mis_fv", 32'(bus.fetch_valid), 32'd0);
        bus.ex_branch_taken = 1; bus.ex_branch_target = 32'h100;
        tick(); tick(); idle();
        chk("halt_frozen", bus.pc, 32'h48);

        reset = 1; tick(); reset = 0;
        chk("rst_err", 32'(bus.misalign_err), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_cnt", 32'(bus.redirect_cnt), 32'd0);
        chk("rst_pc", bus.pc, 32'h0);

        // halt_req waits for stall to drop, then halts with PC held.
        tick();
        bus.halt_req = 1; bus.stall = 1;
        tick();
        chk("halt_stalled", 32'(bus.halted), 32'd0);
        bus.stall = 0;
        tick(); idle();
        chk("halt_taken", 32'(bus.halted), 32'd1);
        chk("halt_pc", bus.pc, 32'h0);
        reset = 1; tick(); reset = 0;
        chk("halt_rst", 32'(bus.halted), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
